// File: rtl/control32_pkg.sv
// +--------------------------------------------------------------------------+
// | control32_pkg                                                            |
// | Shared types and encodings for the multi-cycle MIPS control unit.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package control32_pkg;

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEM       = 3'd3,
      WRITEBACK = 3'd4,
      HALT      = 3'd5
   } state_e;

   localparam logic [5:0] c_op_rtype = 6'h00;
   localparam logic [5:0] c_op_j     = 6'h02;
   localparam logic [5:0] c_op_jal   = 6'h03;
   localparam logic [5:0] c_op_beq   = 6'h04;
   localparam logic [5:0] c_op_bne   = 6'h05;
   localparam logic [5:0] c_op_lw    = 6'h23;
   localparam logic [5:0] c_op_sw    = 6'h2B;
   localparam logic [5:0] c_fn_jr    = 6'h08;

   localparam logic [1:0] c_pc_seq    = 2'b00;
   localparam logic [1:0] c_pc_branch = 2'b01;
   localparam logic [1:0] c_pc_jump   = 2'b10;
   localparam logic [1:0] c_pc_reg    = 2'b11;

   localparam logic [1:0] c_aluop_mem    = 2'b00;
   localparam logic [1:0] c_aluop_branch = 2'b01;
   localparam logic [1:0] c_aluop_func   = 2'b10;

   typedef struct packed {
      logic       is_r;
      logic       is_i;
      logic       is_lw;
      logic       is_sw;
      logic       is_beq;
      logic       is_bne;
      logic       is_j;
      logic       is_jal;
      logic       is_jr;
      logic       illegal;
      logic [1:0] alu_op;
      logic       alu_src;
      logic       i_format;
      logic       sftmd;
      logic       jr;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       jal;
   } decode_t;

   // R-type functions the datapath implements (jr is handled separately).
   function automatic logic funct_legal(input logic [5:0] fn);
      case (fn)
         6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
         6'h2A, 6'h2B: return 1'b1;
         default:      return 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_decode32.sv
// +--------------------------------------------------------------------------+
// | instr_decode32                                                           |
// | Pure combinational decode of the latched instruction into control bits.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_decode32
   import control32_pkg::*;
(
   input  logic [31:0] ir_i,
   output decode_t     dec_o
);

   logic [5:0]  w_op;
   logic [5:0]  w_fn;
   logic [19:0] w_unused_fields;

   assign w_op            = ir_i[31:26];
   assign w_fn            = ir_i[5:0];
   // Register and immediate fields belong to the datapath, not to control.
   assign w_unused_fields = ir_i[25:6];

   always_comb begin
      dec_o = '0;
      case (w_op)
         c_op_rtype: begin
            if (w_fn == c_fn_jr) begin
               dec_o.is_jr = 1'b1;
               dec_o.jr    = 1'b1;
            end else if (funct_legal(w_fn)) begin
               dec_o.is_r    = 1'b1;
               dec_o.alu_op  = c_aluop_func;
               dec_o.reg_dst = 1'b1;
               dec_o.sftmd   = (w_fn[5:3] == 3'b000);
            end else begin
               dec_o.illegal = 1'b1;
            end
         end
         c_op_j: dec_o.is_j = 1'b1;
         c_op_jal: begin
            dec_o.is_jal = 1'b1;
            dec_o.jal    = 1'b1;
         end
         c_op_beq: begin
            dec_o.is_beq = 1'b1;
            dec_o.alu_op = c_aluop_branch;
         end
         c_op_bne: begin
            dec_o.is_bne = 1'b1;
            dec_o.alu_op = c_aluop_branch;
         end
         c_op_lw: begin
            dec_o.is_lw      = 1'b1;
            dec_o.alu_op     = c_aluop_mem;
            dec_o.alu_src    = 1'b1;
            dec_o.mem_to_reg = 1'b1;
         end
         c_op_sw: begin
            dec_o.is_sw   = 1'b1;
            dec_o.alu_op  = c_aluop_mem;
            dec_o.alu_src = 1'b1;
         end
         default: begin
            if (w_op[5:3] == 3'b001) begin
               dec_o.is_i     = 1'b1;
               dec_o.alu_op   = c_aluop_func;
               dec_o.alu_src  = 1'b1;
               dec_o.i_format = 1'b1;
            end else begin
               dec_o.illegal = 1'b1;
            end
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_control32.sv
// +--------------------------------------------------------------------------+
// | multicycle_control32                                                     |
// | FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the 32-bit MIPS core.   |
// | Option: define ILLEGAL_TRAP_EN to halt on unknown opcodes/functs.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module multicycle_control32
   import control32_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] Instruction,
   input  logic        inst_ready,
   input  logic        mem_ready,
   input  logic        Zero,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic [1:0]  PCSrc,
   output logic [1:0]  ALUOp,
   output logic        ALUSrc,
   output logic        I_format,
   output logic        Sftmd,
   output logic        Jr,
   output logic        RegDST,
   output logic        RegWrite,
   output logic        MemtoReg,
   output logic        Jal,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        bus_err,
   output logic [2:0]  state
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic        illegal_instr
`endif
);

   localparam int            CW          = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] c_wait_last = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_e        state_q, state_d;
   logic [31:0]   ir_q;
   logic          ir_valid_q;
   logic [CW-1:0] wait_q, wait_d;
   logic          bus_err_q, bus_err_d;
   logic          w_limit;
   logic          w_tmo;
   decode_t       w_dec;
`ifdef ILLEGAL_TRAP_EN
   logic          illegal_q, illegal_d;
`endif

   instr_decode32 u_decode (
      .ir_i  (ir_q),
      .dec_o (w_dec)
   );

   assign w_limit = (MEM_TIMEOUT != 0) && (wait_q == c_wait_last);

   // Reset clears IR to a word that would decode as sll, so gate until first fetch.
   assign ALUOp    = ir_valid_q ? w_dec.alu_op     : 2'b00;
   assign ALUSrc   = ir_valid_q & w_dec.alu_src;
   assign I_format = ir_valid_q & w_dec.i_format;
   assign Sftmd    = ir_valid_q & w_dec.sftmd;
   assign Jr       = ir_valid_q & w_dec.jr;
   assign RegDST   = ir_valid_q & w_dec.reg_dst;
   assign MemtoReg = ir_valid_q & w_dec.mem_to_reg;
   assign Jal      = ir_valid_q & w_dec.jal;
   assign state    = state_q;
   assign bus_err  = bus_err_d;
`ifdef ILLEGAL_TRAP_EN
   assign illegal_instr = illegal_q;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= FETCH;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         wait_q     <= '0;
         bus_err_q  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
         illegal_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         bus_err_q <= bus_err_d;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
         if (IRWrite) begin
            ir_q       <= Instruction;
            ir_valid_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      wait_d   = '0;
      w_tmo    = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = c_pc_seq;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      case (state_q)
         FETCH: begin
            if (inst_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = DECODE;
            end else if (w_limit) begin
               w_tmo   = 1'b1;
               state_d = HALT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         DECODE: begin
            if (w_dec.is_j) begin
               PCWrite = 1'b1;
               PCSrc   = c_pc_jump;
               state_d = FETCH;
`ifdef ILLEGAL_TRAP_EN
            end else if (w_dec.illegal) begin
               illegal_d = 1'b1;
               state_d   = HALT;
`endif
            end else begin
               state_d = EXECUTE;
            end
         end
         EXECUTE: begin
            if (w_dec.illegal) begin
               state_d = FETCH;
            end else if (w_dec.is_beq || w_dec.is_bne) begin
               if ((w_dec.is_beq && Zero) || (w_dec.is_bne && !Zero)) begin
                  PCWrite = 1'b1;
                  PCSrc   = c_pc_branch;
               end
               state_d = FETCH;
            end else if (w_dec.is_jr) begin
               PCWrite = 1'b1;
               PCSrc   = c_pc_reg;
               state_d = FETCH;
            end else if (w_dec.is_lw || w_dec.is_sw) begin
               state_d = MEM;
            end else if (w_dec.is_r || w_dec.is_i || w_dec.is_jal) begin
               state_d = WRITEBACK;
            end else begin
               state_d = FETCH;
            end
         end
         MEM: begin
            if (mem_ready) begin
               MemRead  = w_dec.is_lw;
               MemWrite = w_dec.is_sw;
               state_d  = w_dec.is_lw ? WRITEBACK : FETCH;
            end else if (w_limit) begin
               w_tmo   = 1'b1;
               state_d = HALT;
            end else begin
               MemRead  = w_dec.is_lw;
               MemWrite = w_dec.is_sw;
               wait_d   = wait_q + 1'b1;
            end
         end
         WRITEBACK: begin
            RegWrite = 1'b1;
            if (w_dec.is_jal) begin
               PCWrite = 1'b1;
               PCSrc   = c_pc_jump;
            end
            state_d = FETCH;
         end
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
      bus_err_d = bus_err_q | w_tmo;
   end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control32.sv
// +--------------------------------------------------------------------------+
// | tb_multicycle_control32                                                  |
// | Directed per-instruction traces checked cycle by cycle against the DUT.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_control32;

   localparam int TMO = 4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] Instruction;
   logic        inst_ready, mem_ready, Zero;
   logic        IRWrite, PCWrite, ALUSrc, I_format, Sftmd, Jr, RegDST, RegWrite;
   logic        MemtoReg, Jal, MemRead, MemWrite, bus_err;
   logic [1:0]  PCSrc, ALUOp;
   logic [2:0]  state;
`ifdef ILLEGAL_TRAP_EN
   logic        illegal_instr;
`endif

   multicycle_control32 #(.MEM_TIMEOUT(TMO)) dut (
      .clock(clock), .reset_n(reset_n), .Instruction(Instruction),
      .inst_ready(inst_ready), .mem_ready(mem_ready), .Zero(Zero),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUOp(ALUOp),
      .ALUSrc(ALUSrc), .I_format(I_format), .Sftmd(Sftmd), .Jr(Jr),
      .RegDST(RegDST), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Jal(Jal),
      .MemRead(MemRead), .MemWrite(MemWrite), .bus_err(bus_err), .state(state)
`ifdef ILLEGAL_TRAP_EN
      , .illegal_instr(illegal_instr)
`endif
   );

   always #5 clock = ~clock;

   typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_BAD} kind_e;

   // strb = {IRWrite, PCWrite, RegWrite, MemRead, MemWrite, bus_err}
   // dec  = {ALUOp, ALUSrc, I_format, Sftmd, Jr, RegDST, MemtoReg, Jal}
   typedef struct {
      logic [31:0] ins;
      logic        z;
      logic        ir;
      logic        mr_in;
      logic [2:0]  st;
      logic [5:0]  strb;
      logic [1:0]  pcsrc;
      logic        chk_dec;
      logic [8:0]  dec;
   } cyc_t;

   cyc_t tr[$];
   cyc_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   mr_cnt = 0;
   int   rw_cnt = 0;

   function automatic kind_e classify(input logic [31:0] ins);
      logic [5:0] op;
      logic [5:0] fn;
      op = ins[31:26];
      fn = ins[5:0];
      if (op == 6'd0) begin
         if (fn == 6'd8) return K_JR;
         if (fn inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, [6'd32:6'd39], 6'd42, 6'd43}) return K_R;
         return K_BAD;
      end
      if (op == 6'd2) return K_J;
      if (op == 6'd3) return K_JAL;
      if (op == 6'd4) return K_BEQ;
      if (op == 6'd5) return K_BNE;
      if (op >= 6'd8 && op <= 6'd15) return K_I;
      if (op == 6'd35) return K_LW;
      if (op == 6'd43) return K_SW;
      return K_BAD;
   endfunction

   function automatic logic [8:0] exp_dec(input kind_e k, input logic [5:0] fn);
      case (k)
         K_R:          return {2'b10, 1'b0, 1'b0, (fn[5:3] == 3'b000), 1'b0, 1'b1, 1'b0, 1'b0};
         K_I:          return 9'b10_1100000;
         K_LW:         return 9'b00_1000010;
         K_SW:         return 9'b00_1000000;
         K_BEQ, K_BNE: return 9'b01_0000000;
         K_JR:         return 9'b00_0001000;
         K_JAL:        return 9'b00_0000001;
         default:      return 9'b0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected cycle-by-cycle trace of one instruction; fw/mw are ready-low cycles.
   task automatic build(input logic [31:0] ins, input logic z, input int fw, input int mw);
      kind_e k;
      cyc_t  b, c;
      k = classify(ins);
      b = '{ins: ins, z: z, ir: 1'b0, mr_in: 1'b0, st: 3'd0, strb: 6'b0,
             pcsrc: 2'b0, chk_dec: 1'b0, dec: exp_dec(k, ins[5:0])};
      for (int i = 0; i < fw; i++) tr.push_back(b);
      c = b; c.ir = 1'b1; c.strb = 6'b110000; tr.push_back(c);
      c = b; c.st = 3'd1;
      if (k == K_J) begin
         c.strb = 6'b010000; c.pcsrc = 2'd2; tr.push_back(c);
         return;
      end
      tr.push_back(c);
      c = b; c.st = 3'd2; c.chk_dec = 1'b1;
      if ((k == K_BEQ && z) || (k == K_BNE && !z)) begin
         c.strb = 6'b010000; c.pcsrc = 2'd1;
      end
      if (k == K_JR) begin
         c.strb = 6'b010000; c.pcsrc = 2'd3;
      end
      tr.push_back(c);
      if (k inside {K_BEQ, K_BNE, K_JR, K_BAD}) return;
      if (k == K_LW || k == K_SW) begin
         for (int i = 0; i <= mw; i++) begin
            c = b; c.st = 3'd3; c.chk_dec = 1'b1; c.mr_in = (i == mw);
            if (i == TMO - 1 && i != mw) begin
               c.strb = 6'b000001; tr.push_back(c);
               c = b; c.st = 3'd5; c.strb = 6'b000001;
               for (int h = 0; h < 3; h++) tr.push_back(c);
               return;
            end
            c.strb = (k == K_LW) ? 6'b000100 : 6'b000010;
            tr.push_back(c);
         end
         if (k == K_SW) return;
      end
      c = b; c.st = 3'd4; c.chk_dec = 1'b1; c.strb = 6'b001000;
      if (k == K_JAL) begin
         c.strb = 6'b011000; c.pcsrc = 2'd2;
      end
      tr.push_back(c);
   endtask

   // Called at a falling edge; returns at the falling edge after the last cycle.
   task automatic run();
      cyc_t c;
      while (tr.size() > 0) begin
         c           = tr.pop_front();
         Instruction = c.ins;
         Zero        = c.z;
         inst_ready  = c.ir;
         mem_ready   = c.mr_in;
         exp_q.push_back(c);
         @(negedge clock);
      end
   endtask

   initial begin : compare
      cyc_t e;
      forever begin
         @(negedge clock);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state", 32'(state), 32'(e.st));
            check("strobes", 32'({IRWrite, PCWrite, RegWrite, MemRead, MemWrite, bus_err}), 32'(e.strb));
            if (e.strb[4]) check("PCSrc", 32'(PCSrc), 32'(e.pcsrc));
            if (e.chk_dec)
               check("decode", 32'({ALUOp, ALUSrc, I_format, Sftmd, Jr, RegDST, MemtoReg, Jal}), 32'(e.dec));
            if (MemRead) mr_cnt++;
            if (RegWrite) rw_cnt++;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      reset_n     = 1'b0;
      Instruction = 32'h0;
      inst_ready  = 1'b0;
      mem_ready   = 1'b0;
      Zero        = 1'b0;
      #2;
      check("rst_state", 32'(state), 32'd0);
      check("rst_strobes", 32'({IRWrite, PCWrite, RegWrite, MemRead, MemWrite, bus_err}), 32'd0);
      check("rst_decode", 32'({ALUOp, ALUSrc, I_format, Sftmd, Jr, RegDST, MemtoReg, Jal, PCSrc}), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      build(32'h00221820, 1'b0, 0, 0);          // add $3,$1,$2
      check("len_add", tr.size(), 4);
      rw_cnt = 0; run();
      check("add_regwrite_cycles", rw_cnt, 1);

      build(32'h8C220004, 1'b0, 0, 2);          // lw, memory ready on 3rd MEM cycle
      check("len_lw_wait", tr.size(), 7);
      mr_cnt = 0; run();
      check("lw_memread_cycles", mr_cnt, 3);

      build(32'h10220003, 1'b1, 0, 0);          // beq taken
      check("len_beq", tr.size(), 3);
      run();
      build(32'h10220003, 1'b0, 0, 0); run();   // beq not taken
      build(32'h14220003, 1'b0, 0, 0); run();   // bne taken
      build(32'h14220003, 1'b1, 0, 0); run();   // bne not taken
      build(32'h00021080, 1'b0, 0, 0); run();   // sll
      build(32'h03E00008, 1'b0, 0, 0);          // jr $31
      rw_cnt = 0; run();
      check("jr_regwrite_cycles", rw_cnt, 0);
      build(32'h08000010, 1'b0, 0, 0);          // j
      check("len_j", tr.size(), 2);
      run();
      build(32'h0C000010, 1'b0, 0, 0); run();   // jal
      build(32'h20220005, 1'b0, 2, 0); run();   // addi with two fetch wait cycles
      build(32'hAC220004, 1'b0, 0, 1); run();   // sw with one MEM wait cycle
      build(32'h8C220004, 1'b0, 0, 0);          // lw zero-wait
      check("len_lw", tr.size(), 5);
      run();
      build(32'hFC000000, 1'b0, 0, 0); run();   // unknown opcode
      build(32'h00000001, 1'b0, 0, 0); run();   // unknown funct

      // Asynchronous reset while a store is waiting in MEM.
      build(32'hAC220004, 1'b0, 0, 3);
      tr = tr[0:4];
      run();
      #2;
      check("midmem_memwrite", 32'(MemWrite), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      check("async_memwrite", 32'(MemWrite), 32'd0);
      check("async_state", 32'(state), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      build(32'h00221820, 1'b0, 0, 0); run();

      // Data memory never answers: bus error on the TMO-th wait cycle, then HALT.
      build(32'h8C220004, 1'b0, 0, TMO);
      check("len_timeout", tr.size(), 10);
      mr_cnt = 0; run();
      check("timeout_memread_cycles", mr_cnt, 3);
      reset_n = 1'b0;
      #2;
      check("halt_reset_buserr", 32'(bus_err), 32'd0);
      check("halt_reset_state", 32'(state), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      build(32'h00221820, 1'b0, 0, 0); run();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
